// File: rtl/halli_galli_key_input.sv
// Button front end for the Halli Galli game controller. Each button is synchronized and
// debounced. Each debounced press becomes a one-entry valid/ready key event, and lost events set a sticky drop flag.
module halli_galli_key_input #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        b1,
  input  logic        b2,
  input  logic        b3,
  input  logic        b4,
  input  logic        b5,
  input  logic        b6,
  input  logic        b7,
  input  logic        b8,
  input  logic        b9,
  input  logic        b10,
  input  logic        b11,
  input  logic        b12,
  input  logic        key_ready,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [11:0] held,
  output logic        key_drop
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [11:0]   w_raw;
  logic [11:0]   r_s1;
  logic [11:0]   r_s2;
  logic [11:0]   r_stable;
  logic [CW-1:0] r_cnt [12];
  logic [11:0]   w_press;
  logic          w_hasEvent;
  logic          w_lost;
  logic [3:0]    w_code;
  logic          w_transfer;

  assign w_raw = {b12, b11, b10, b9, b8, b7, b6, b5, b4, b3, b2, b1};

  // A stable level flips on the last disagreeing edge; a press is a 0->1 flip.
  always_comb begin
    w_press = '0;
    for (int i = 0; i < 12; i++) begin
      w_press[i] = r_s2[i] && !r_stable[i] && (r_cnt[i] == LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_stable <= '0;
      for (int i = 0; i < 12; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
      for (int i = 0; i < 12; i++) begin
        if (r_s2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == LAST) begin
          r_stable[i] <= r_s2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Lowest-numbered button wins; any additional simultaneous press is lost.
  always_comb begin
    w_code = 4'd0;
    for (int i = 11; i >= 0; i--) begin
      if (w_press[i]) begin
        w_code = 4'(i + 1);
      end
    end
    w_hasEvent = |w_press;
    w_lost     = |(w_press & (w_press - 12'd1));
  end

  assign w_transfer = key_valid && key_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      key_valid <= 1'b0;
      key_code  <= 4'd0;
      key_drop  <= 1'b0;
    end else begin
      if (w_lost) begin
        key_drop <= 1'b1;
      end
      if (w_hasEvent) begin
        if (!key_valid || w_transfer) begin
          key_valid <= 1'b1;
          key_code  <= w_code;
        end else begin
          key_drop <= 1'b1;
        end
      end else if (w_transfer) begin
        key_valid <= 1'b0;
        key_code  <= 4'd0;
      end
    end
  end

  assign held = r_stable;

endmodule

// File: tb/tb_halli_galli_key_input.sv
// Bench for halli_galli_key_input: directed scenarios with literal expectations plus random
// button/ready/reset activity checked every cycle against a behavioural model.
module tb_halli_galli_key_input;

  localparam int D = 4;

  logic        clk;
  logic        rst;
  logic [11:0] buttons;
  logic        key_ready;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [11:0] held;
  logic        key_drop;

  int testsRun;
  int testsFailed;
  bit checkEnable;

  halli_galli_key_input #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst),
    .b1(buttons[0]), .b2(buttons[1]), .b3(buttons[2]), .b4(buttons[3]),
    .b5(buttons[4]), .b6(buttons[5]), .b7(buttons[6]), .b8(buttons[7]),
    .b9(buttons[8]), .b10(buttons[9]), .b11(buttons[10]), .b12(buttons[11]),
    .key_ready(key_ready), .key_valid(key_valid), .key_code(key_code),
    .held(held), .key_drop(key_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a button's synchronized sample is its raw value two edges earlier; the stable
  // level flips after D consecutive edges of disagreement.
  logic [11:0] mStable;
  int          mRun [12];
  logic [11:0] mHist [$];
  bit          mValid;
  int          mCode;
  bit          mDrop;

  initial begin
    mStable = '0;
    mValid  = 0;
    mCode   = 0;
    mDrop   = 0;
    for (int i = 0; i < 12; i++) mRun[i] = 0;
    mHist = '{12'h000, 12'h000};
  end

  always @(posedge clk) begin
    logic [11:0] syncNow;
    logic [11:0] presses;
    bit          transfer;
    int          winner;
    if (rst) begin
      mStable = '0;
      for (int i = 0; i < 12; i++) mRun[i] = 0;
      mHist  = '{12'h000, 12'h000};
      mValid = 0;
      mCode  = 0;
      mDrop  = 0;
    end else begin
      syncNow = mHist.pop_front();
      mHist.push_back(buttons);
      presses = '0;
      for (int i = 0; i < 12; i++) begin
        if (syncNow[i] == mStable[i]) begin
          mRun[i] = 0;
        end else begin
          mRun[i] = mRun[i] + 1;
          if (mRun[i] == D) begin
            mStable[i] = syncNow[i];
            mRun[i] = 0;
            if (syncNow[i]) presses[i] = 1'b1;
          end
        end
      end
      transfer = mValid && key_ready;
      winner = 0;
      for (int i = 11; i >= 0; i--) if (presses[i]) winner = i + 1;
      if ($countones(presses) > 1) mDrop = 1;
      if (winner != 0) begin
        if (!mValid || transfer) begin
          mValid = 1;
          mCode  = winner;
        end else begin
          mDrop = 1;
        end
      end else if (transfer) begin
        mValid = 0;
        mCode  = 0;
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEnable) begin
      checkOutput("model key_valid", int'(key_valid), int'(mValid));
      checkOutput("model key_code", int'(key_code), mCode);
      checkOutput("model held", int'(held), int'(mStable));
      checkOutput("model key_drop", int'(key_drop), int'(mDrop));
    end
  end

  // Drive inputs just after a falling edge, then let the given number of cycles elapse.
  task automatic applyStimulus(input logic [11:0] btn, input logic rdy, input int cycles);
    buttons   = btn;
    key_ready = rdy;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    logic [11:0] rbtn;
    testsRun    = 0;
    testsFailed = 0;
    checkEnable = 0;
    rst       = 1'b1;
    buttons   = '0;
    key_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkEnable = 1;
    checkOutput("reset key_valid", int'(key_valid), 0);
    checkOutput("reset key_code", int'(key_code), 0);
    checkOutput("reset held", int'(held), 0);
    checkOutput("reset key_drop", int'(key_drop), 0);

    applyStimulus(12'h001, 1'b0, 5);
    checkOutput("b1 not before E+5", int'(key_valid), 0);
    applyStimulus(12'h001, 1'b0, 1);
    checkOutput("b1 valid at E+5", int'(key_valid), 1);
    checkOutput("b1 code", int'(key_code), 1);
    applyStimulus(12'h001, 1'b1, 1);
    checkOutput("b1 accepted", int'(key_valid), 0);
    checkOutput("b1 held after accept", int'(held[0]), 1);
    applyStimulus(12'h001, 1'b0, 3);
    applyStimulus(12'h000, 1'b0, 10);
    checkOutput("b1 released", int'(held), 0);

    applyStimulus(12'h004, 1'b0, 3);
    applyStimulus(12'h000, 1'b0, 10);
    checkOutput("glitch valid", int'(key_valid), 0);
    checkOutput("glitch held", int'(held), 0);
    checkOutput("glitch drop", int'(key_drop), 0);

    applyStimulus(12'h005, 1'b0, 6);
    checkOutput("tie valid", int'(key_valid), 1);
    checkOutput("tie code", int'(key_code), 1);
    checkOutput("tie drop", int'(key_drop), 1);
    applyStimulus(12'h005, 1'b1, 1);
    applyStimulus(12'h005, 1'b0, 8);
    checkOutput("tie no b3 event", int'(key_valid), 0);
    applyStimulus(12'h000, 1'b0, 10);

    applyStimulus(12'h002, 1'b0, 8);
    checkOutput("pending b2 code", int'(key_code), 2);
    applyStimulus(12'h008, 1'b0, 4);
    rst = 1'b1;
    applyStimulus(12'h008, 1'b0, 1);
    rst = 1'b0;
    checkOutput("midrst key_valid", int'(key_valid), 0);
    checkOutput("midrst key_code", int'(key_code), 0);
    checkOutput("midrst held", int'(held), 0);
    checkOutput("midrst key_drop", int'(key_drop), 0);
    applyStimulus(12'h008, 1'b0, 5);
    checkOutput("held-through-rst early", int'(key_valid), 0);
    applyStimulus(12'h008, 1'b0, 1);
    checkOutput("held-through-rst code", int'(key_code), 4);
    applyStimulus(12'h008, 1'b1, 1);
    applyStimulus(12'h000, 1'b0, 10);

    for (int k = 0; k < 6; k++) begin
      applyStimulus((k % 2 == 1) ? 12'h004 : 12'h001, 1'b1, 8);
      applyStimulus(12'h000, 1'b1, 8);
    end
    checkOutput("alternating no drop", int'(key_drop), 0);
    checkOutput("alternating drained", int'(key_valid), 0);

    rbtn = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) rbtn[$urandom_range(0, 11)] ^= 1'b1;
      if ($urandom_range(0, 60) == 0) rbtn = rbtn | 12'($urandom_range(0, 4095));
      if ($urandom_range(0, 60) == 0) rbtn = '0;
      rst = ($urandom_range(0, 400) == 0);
      applyStimulus(rbtn, 1'($urandom_range(0, 1)), 1);
    end
    rst = 1'b0;
    applyStimulus(12'h000, 1'b1, 12);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/halli_galli_key_input.md
# halli_galli_key_input

Front-end button conditioner feeding `top_Halli_Galli`'s game controller. It synchronizes and debounces the twelve raw push-buttons `b1`..`b12` and turns each debounced press into a single key event. Each event carries a 4-bit key code and is held in a one-entry valid/ready output register until the game FSM accepts it. It also exports debounced button levels and a sticky dropped-event flag.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive sampling edges a synchronized input must disagree with its stable level before the stable level flips; legal range 1..255 (board build uses a larger value).
- `clk` input 1: single system clock; all flops on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `b1`..`b12` input 1 each: raw asynchronous push-buttons, 1 = pressed.
- `key_ready` input 1: game FSM accepts the current event this cycle.
- `key_valid` output 1: event pending in the output register.
- `key_code` output 4: pressed button number, 1..12; 0 when `key_valid`=0.
- `held` output 12: debounced levels; bit i-1 corresponds to `b`i.
- `key_drop` output 1: sticky; set when any press event is discarded.

## Operation
- Per button: two-flop synchronizer `s1`, `s2`, a stable register, and a counter of width clog2(`DEBOUNCE_CYCLES`+1).
- Debounce at each edge:
  - `s2` == stable: counter <= 0.
  - `s2` != stable and counter < `DEBOUNCE_CYCLES`-1: counter increments.
  - `s2` != stable and counter == `DEBOUNCE_CYCLES`-1: stable <= `s2` and counter <= 0.
- Press event: the stable level flips 0->1 at this edge. A 1->0 flip (release) produces no event.
- A glitch shorter than `DEBOUNCE_CYCLES` sampling edges restarts the counter and produces no event and no `held` change.
- Simultaneous press events in one cycle: the lowest-numbered button wins (`b1` highest priority). Each losing event is discarded and sets `key_drop`.
- Output register is one entry, updated on each edge:
  - transfer = `key_valid` & `key_ready`.
  - New event and (`key_valid`=0 or transfer): load `key_code`, `key_valid` <= 1.
  - New event while `key_valid`=1 and not transfer: event discarded, `key_code` unchanged, `key_drop` <= 1.
  - Transfer with no new event: `key_valid` <= 0, `key_code` <= 0.
  - Transfer and new event in the same cycle: the new event loads with no bubble; `key_valid` stays 1.
- `key_ready` while `key_valid`=0 is ignored.
- `key_drop` clears only on `rst`.
- `held` equals the stable registers.

## Timing
- Reset values: `key_valid`=0, `key_code`=0, `held`=0, `key_drop`=0; all synchronizers, stable registers and counters 0.
- `rst` mid-operation discards any pending event and any partial debounce count.
- A button already held at reset release yields one press event, `DEBOUNCE_CYCLES`+2 edges after release.
- Press latency, with E the first edge sampling `b`i=1:
  - `s1`=1 after E; `s2`=1 after E+1.
  - Stable, `held` bit, `key_valid`=1 and `key_code`=i all appear after edge E+`DEBOUNCE_CYCLES`+1 (after E+5 for the default).
- Minimum accepted press: `b`i high at `DEBOUNCE_CYCLES` consecutive sampling edges. Release requires the same.
- Pulses narrower than one clock period may be missed entirely; this is required behaviour.
- Output changes are registered only; no combinational path from `b`i or `key_ready` to any output.

## Test plan
- Reset, then `b1`=1 held for 10 cycles (D=4) -> `key_valid`=1, `key_code`=1 exactly 6 edges after the first sampling edge. With `key_ready`=1 one cycle later, `key_valid` drops next edge and `held[0]` stays 1 until release debounces.
- `b3` high for only 3 sampling edges (D=4) -> no event; `held`=0; `key_drop`=0.
- `b1` and `b3` rise on the same edge with `key_ready`=0 -> `key_code`=1, `key_drop`=1. After accept, no event for `b3`.
- Alternating presses 1,3,1,3,1,3 (each held 8 cycles, 8 cycles apart), `key_ready` tied high -> six single-cycle `key_valid` pulses with codes 1,3,1,3,1,3; `key_drop`=0.
- `key_valid` pending with `key_ready`=0 when `b2` is pressed -> `key_code` unchanged, `key_drop`=1. Then a press of `b5` debounces on the same edge as `key_ready`=1 -> `key_code`=5 next cycle, `key_valid` never deasserts.
- `rst` asserted one cycle before a debounce would complete, with an event also pending -> all outputs 0 next edge. Button still held after release -> event 6 edges later.
